io_ccff_loader: RTL
===================

Name: io_ccff_loader

Overview:
- Configuration-chain controller for an IO grid column (8 IO subtiles, one ccff bit each, daisy-chained head to tail).
- Accepts bitstream words from the programming host over a valid/ready handshake and serialises them onto ccff_head.
- Emits a shift enable that integration uses to gate the chain's clock.
- Optionally verifies the loaded chain by recirculating it once, non-destructively, and comparing ccff_tail against a local mirror.

Parameters:
- CHAIN_LEN, 8, number of ccff bits in the chain being driven (>=2).
- WORD_W, 8, width of host bitstream words (>=1).

Ports:
- prog_clk  input  1  programming clock; all state on rising edge.
- prog_reset_n  input  1  asynchronous, active-low reset.
- start  input  1  load request; sampled only in IDLE.
- verify_en  input  1  sampled with start; 1 = run VERIFY after LOAD.
- cfg_data  input  WORD_W  bitstream word; bit 0 is shifted first.
- cfg_valid  input  1  host word valid.
- cfg_ready  output  1  word accepted when cfg_valid & cfg_ready.
- ccff_head  output  1  serial data to the chain head.
- ccff_tail  input  1  serial data from the chain tail.
- ccff_shift_en  output  1  chain advances on each prog_clk edge where this is 1.
- busy  output  1  high in LOAD and VERIFY.
- done  output  1  one-cycle pulse at end of operation.
- cfg_err  output  1  sticky verify mismatch; cleared on accepted start.

Behaviour:
- Reset (async, prog_reset_n=0): state IDLE. All outputs 0 (cfg_ready, ccff_head, ccff_shift_en, busy, done, cfg_err). Counters, buffer and mirror cleared. Chain contents after a mid-operation reset are undefined, and done is not pulsed.
- Derived values: NWORDS = ceil(CHAIN_LEN/WORD_W). Counters are $clog2(CHAIN_LEN+1) bits wide.
- States: IDLE, LOAD, VERIFY, DONE.
- IDLE:
  - start=1 -> LOAD. Clears bit_cnt, word_cnt and cfg_err; latches verify_en.
  - start in any other state is ignored.
- LOAD, word buffer:
  - Holds buf[WORD_W-1:0] and buf_cnt (valid bits remaining).
  - cfg_ready = (word_cnt < NWORDS) && (buf_cnt==0 || (buf_cnt==1 && ccff_shift_en)). This allows back-to-back words with no bubble.
  - On accept: buf <= cfg_data; buf_cnt <= min(WORD_W, CHAIN_LEN - bits already accepted); word_cnt++.
  - Upper bits of a final partial word are discarded.
- LOAD, shifting:
  - ccff_shift_en = (buf_cnt>0); ccff_head = buf[0] (combinational from register).
  - On each shift: buf >>= 1, buf_cnt--, bit_cnt++, mirror[bit_cnt] <= buf[0].
  - cfg_valid low: buffer drains, then shift_en=0 and the chain holds (stall, no data loss).
  - bit_cnt reaching CHAIN_LEN -> VERIFY if verify latched, else DONE.
- VERIFY:
  - ccff_shift_en=1 for exactly CHAIN_LEN cycles; ccff_head = ccff_tail (recirculate).
  - On cycle j (0..CHAIN_LEN-1), ccff_tail is compared with mirror[j]; any mismatch sets cfg_err.
  - After the last cycle -> DONE. Chain contents equal the loaded pattern again.
- DONE: done=1 for one cycle, busy=0, cfg_ready=0, shift_en=0; -> IDLE.
- busy=1 exactly in LOAD and VERIFY.
- cfg_err holds until the next accepted start.
- Latency without stalls (WORD_W >= CHAIN_LEN), counted from the edge sampling start:
  - done is high CHAIN_LEN+2 cycles later without verify.
  - done is high 2*CHAIN_LEN+2 cycles later with verify.

Test Plan:
- CHAIN_LEN=8, WORD_W=8, verify_en=1, cfg_data=0xA5, bench 8-FF chain model -> chain holds 0xA5 (first-shifted bit at tail), cfg_err=0, done pulses exactly 18 cycles after start, 16 shift_en cycles total.
- Same with verify_en=0 -> 8 shift cycles, done at cycle 10, cfg_ready asserted for exactly one handshake.
- CHAIN_LEN=10, WORD_W=4, words 0xF,0x0,0xE (bits 3:2 of last discarded) with cfg_valid dropped 3 cycles after word 1 -> shift_en low during stall, chain=bit pattern 1111_0000_01, exactly 3 handshakes.
- Bench model flips chain FF 3 after LOAD -> VERIFY flags cfg_err=1, done still pulses. Next start clears cfg_err, and a clean reload gives cfg_err=0.
- prog_reset_n pulsed low mid-LOAD -> all outputs 0 immediately (async), no done. A subsequent start reloads correctly.
- start held high through LOAD/VERIFY -> ignored; exactly one done per accepted start.

Source files
------------

// File: rtl/io_ccff_loader.sv
// Configuration-chain loader: serialises host words onto an IO-column ccff chain,
// then optionally recirculates the chain once to check it against a local mirror.
module io_ccff_loader #(
  parameter int CHAIN_LEN = 8,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic              verify_en,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int BC_W   = $clog2(WORD_W + 1);

  localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] NWORDS_C = CNT_W'(NWORDS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_VERIFY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [CNT_W-1:0]     bit_cnt_reg, bit_cnt_next;
  logic [CNT_W-1:0]     word_cnt_reg, word_cnt_next;
  logic [CNT_W-1:0]     acc_cnt_reg, acc_cnt_next;
  logic [CNT_W-1:0]     rem_bits;
  logic [WORD_W-1:0]    buf_reg, buf_next;
  logic [BC_W-1:0]      buf_cnt_reg, buf_cnt_next;
  logic [BC_W-1:0]      take_bits;
  logic [CHAIN_LEN-1:0] mirror_reg, mirror_next;
  logic [CHAIN_LEN-1:0] mism;
  logic                 verify_reg, verify_next;
  logic                 err_reg, err_next;
  logic                 load_shift;

  // A final partial word only contributes the bits the chain still needs.
  assign rem_bits  = LEN_C - acc_cnt_reg;
  assign take_bits = (32'(rem_bits) < 32'(WORD_W)) ? BC_W'(rem_bits) : BC_W'(WORD_W);

  genvar gi;
  generate
    for (gi = 0; gi < CHAIN_LEN; gi++) begin : g_mirror
      assign mirror_next[gi] = (load_shift && (bit_cnt_reg == CNT_W'(gi))) ? buf_reg[0]
                                                                           : mirror_reg[gi];
      assign mism[gi]        = (bit_cnt_reg == CNT_W'(gi)) && (mirror_reg[gi] != ccff_tail);
    end
  endgenerate

  assign cfg_err = err_reg;

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_reg    <= S_IDLE;
      bit_cnt_reg  <= '0;
      word_cnt_reg <= '0;
      acc_cnt_reg  <= '0;
      buf_reg      <= '0;
      buf_cnt_reg  <= '0;
      mirror_reg   <= '0;
      verify_reg   <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      word_cnt_reg <= word_cnt_next;
      acc_cnt_reg  <= acc_cnt_next;
      buf_reg      <= buf_next;
      buf_cnt_reg  <= buf_cnt_next;
      mirror_reg   <= mirror_next;
      verify_reg   <= verify_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    word_cnt_next = word_cnt_reg;
    acc_cnt_next  = acc_cnt_reg;
    buf_next      = buf_reg;
    buf_cnt_next  = buf_cnt_reg;
    verify_next   = verify_reg;
    err_next      = err_reg;
    load_shift    = 1'b0;
    cfg_ready     = 1'b0;
    ccff_head     = 1'b0;
    ccff_shift_en = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next    = S_LOAD;
          bit_cnt_next  = '0;
          word_cnt_next = '0;
          acc_cnt_next  = '0;
          buf_cnt_next  = '0;
          err_next      = 1'b0;
          verify_next   = verify_en;
        end
      end

      S_LOAD: begin
        busy          = 1'b1;
        ccff_head     = buf_reg[0];
        ccff_shift_en = (buf_cnt_reg != '0);
        // Refill while the last buffered bit is going out, so words stream without gaps.
        cfg_ready     = (word_cnt_reg < NWORDS_C) &&
                        ((buf_cnt_reg == '0) || (buf_cnt_reg == BC_W'(1)));
        if (bit_cnt_reg == LEN_C) begin
          state_next   = verify_reg ? S_VERIFY : S_DONE;
          bit_cnt_next = '0;
        end else begin
          if (buf_cnt_reg != '0) begin
            load_shift   = 1'b1;
            buf_next     = buf_reg >> 1;
            buf_cnt_next = buf_cnt_reg - BC_W'(1);
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          end
          if (cfg_valid && cfg_ready) begin
            buf_next      = cfg_data;
            buf_cnt_next  = take_bits;
            word_cnt_next = word_cnt_reg + CNT_W'(1);
            acc_cnt_next  = acc_cnt_reg + CNT_W'(take_bits);
          end
        end
      end

      S_VERIFY: begin
        // One full rotation leaves the chain holding what was loaded.
        busy          = 1'b1;
        ccff_shift_en = 1'b1;
        ccff_head     = ccff_tail;
        err_next      = err_reg | (|mism);
        bit_cnt_next  = bit_cnt_reg + CNT_W'(1);
        if (bit_cnt_reg == LAST_C) begin
          state_next = S_DONE;
        end
      end

      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

endmodule
